// File: rtl/sad_pipe_if.sv
// sad_pipe_if: beat-in / result-out handshake bundle for the SAD engine.
interface sad_pipe_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int ROWS = 4
);
  localparam int OUT_W = WIDTH + $clog2(LANES * ROWS);
  logic clear, in_valid, in_ready, out_valid, out_ready;
  logic [LANES*WIDTH-1:0] in_a, in_b;
  logic [OUT_W-1:0] out_sad;
  modport master(
    output clear, in_valid, in_a, in_b, out_ready,
    input in_ready, out_valid, out_sad
  );
  modport slave(
    input clear, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sad
  );
endinterface

// File: rtl/sad_pipe.sv
// sad_pipe: pipelined sum-of-absolute-differences engine with valid/ready flow control.
module sad_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int ROWS = 4
) (
  input logic clk,
  input logic rst,
  sad_pipe_if.slave bus
);
  localparam int OUT_W = WIDTH + $clog2(LANES * ROWS);
  localparam int SW = WIDTH + $clog2(LANES);
  localparam int CW = ROWS > 1 ? $clog2(ROWS) : 1;
  logic en, last_d;
  logic [CW-1:0] cnt_q;
  logic v1_q, l1_q, v2_q, l2_q, out_valid_q;
  logic [LANES-1:0][WIDTH-1:0] diff_d, d1_q;
  logic [SW-1:0] sum_d, s2_q;
  logic [OUT_W-1:0] acc_q, acc_d, out_sad_q;
  // a pending, unconsumed result freezes the whole pipeline
  assign en = !(out_valid_q && !bus.out_ready);
  assign last_d = cnt_q == CW'(ROWS - 1);
  assign acc_d = acc_q + OUT_W'(s2_q);
  assign bus.in_ready = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sad = out_sad_q;
  always_comb begin
    diff_d = '0;
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      diff_d[i] = bus.in_a[i*WIDTH +: WIDTH] > bus.in_b[i*WIDTH +: WIDTH]
                ? bus.in_a[i*WIDTH +: WIDTH] - bus.in_b[i*WIDTH +: WIDTH]
                : bus.in_b[i*WIDTH +: WIDTH] - bus.in_a[i*WIDTH +: WIDTH];
      sum_d = sum_d + SW'(d1_q[i]);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      v1_q <= 1'b0;
      l1_q <= 1'b0;
      v2_q <= 1'b0;
      l2_q <= 1'b0;
      d1_q <= '0;
      s2_q <= '0;
      acc_q <= '0;
      out_sad_q <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.clear) begin
      cnt_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      acc_q <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      v1_q <= bus.in_valid;
      l1_q <= last_d;
      d1_q <= diff_d;
      if (bus.in_valid) cnt_q <= last_d ? '0 : cnt_q + CW'(1);
      v2_q <= v1_q;
      l2_q <= l1_q;
      s2_q <= sum_d;
      if (v2_q) acc_q <= l2_q ? '0 : acc_d;
      if (v2_q && l2_q) out_sad_q <= acc_d;
      out_valid_q <= v2_q && l2_q;
    end
endmodule

// File: tb/tb_sad_pipe.sv
// tb_sad_pipe: directed SAD blocks with a queue scoreboard checked by an independent monitor.
module tb_sad_pipe;
  logic clk, rst;
  int passed = 0, total = 0;
  int sb[$];
  logic [31:0] a1, b1;
  sad_pipe_if #(.WIDTH(8), .LANES(4), .ROWS(4)) bus();
  sad_pipe #(.WIDTH(8), .LANES(4), .ROWS(4)) dut(.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic logic [31:0] px(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction
  task automatic beat(input logic [31:0] a, input logic [31:0] b);
    bit r;
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    do begin
      #1 r = bus.in_ready;
      @(negedge clk);
      t++;
    end while (!r && t < 100);
    if (!r) check("beat_accept_timeout", 0, 1);
  endtask
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic blk(input logic [31:0] a, input logic [31:0] b, input int exp, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (i == gap) idle(2);
      beat(a, b);
    end
    sb.push_back(exp);
  endtask
  initial begin
    int exp;
    forever begin
      @(negedge clk);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) check("unexpected_result", bus.out_sad, -1);
        else begin
          exp = sb.pop_front();
          check("sad", bus.out_sad, exp);
        end
      end
    end
  end
  initial begin
    a1 = px(10, 20, 30, 40);
    b1 = px(40, 30, 20, 10);
    rst = 1'b1;
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_sad", bus.out_sad, 0);
    check("reset_in_ready", bus.in_ready, 1);
    @(negedge clk);
    blk(32'h0, 32'h0, 0, -1);
    idle(0);
    #1 check("lat_cycle1", bus.out_valid, 0);
    @(negedge clk);
    #1 check("lat_cycle2", bus.out_valid, 0);
    @(negedge clk);
    #1 check("lat_cycle3", bus.out_valid, 1);
    @(negedge clk);
    #1 check("pulse_end", bus.out_valid, 0);
    @(negedge clk);
    blk(a1, b1, 320, -1);
    blk(b1, a1, 320, -1);
    idle(6);
    blk(32'hffffffff, 32'h0, 4080, -1);
    idle(6);
    blk(a1, b1, 320, 2);
    blk(32'hffffffff, 32'h0, 4080, 1);
    idle(6);
    blk(a1, b1, 320, -1);
    bus.out_ready = 1'b0;
    fork
      begin
        blk(32'hffffffff, 32'h0, 4080, -1);
        idle(0);
      end
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          #1;
          check("stall_in_ready", bus.in_ready, 0);
          check("stall_sad_hold", bus.out_sad, 320);
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
    join
    idle(6);
    beat(32'hffffffff, 32'h0);
    beat(32'hffffffff, 32'h0);
    bus.clear = 1'b1;
    bus.in_a = 32'hffffffff;
    bus.in_b = 32'h0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("clear_out_valid", bus.out_valid, 0);
    check("clear_sad_hold", bus.out_sad, 4080);
    @(negedge clk);
    blk(a1, b1, 320, -1);
    idle(6);
    beat(32'hffffffff, 32'h0);
    beat(32'hffffffff, 32'h0);
    rst = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sad", bus.out_sad, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    blk(a1, b1, 320, -1);
    idle(6);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
